// File: rtl/uart_pkg.sv
// Shared constants, state encodings and bit-timing helper for the UART
// time-command receiver.
package uart_pkg;

  localparam logic [7:0] CH_T  = 8'h54;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_0  = 8'h30;
  localparam logic [7:0] CH_9  = 8'h39;

  typedef enum logic [1:0] {
    R_IDLE,
    R_START,
    R_DATA,
    R_STOP
  } rx_state_t;

  typedef enum logic [2:0] {
    P_IDLE,
    P_H1,
    P_H0,
    P_M1,
    P_M0,
    P_END
  } parse_state_t;

  function automatic int calc_div(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_byte_rx.sv
// 8N1 byte receiver: input synchroniser, mid-bit sampling, stop-bit check.
// data/valid and stop_err are registered single-cycle results of the stop sample.
module uart_byte_rx
  import uart_pkg::*;
#(
  parameter int DIV = 1250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] data,
  output logic       valid,
  output logic       stop_err
);

  localparam int HALF = DIV / 2;
  localparam int CW   = (DIV > 2) ? $clog2(DIV) : 1;

  logic [1:0]    sync;
  logic          prev;
  rx_state_t     state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          line;

  assign line = sync[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync     <= 2'b11;
      prev     <= 1'b1;
      state    <= R_IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      data     <= '0;
      valid    <= 1'b0;
      stop_err <= 1'b0;
    end else begin
      sync     <= {sync[0], rxd};
      prev     <= line;
      valid    <= 1'b0;
      stop_err <= 1'b0;
      case (state)
        R_IDLE: begin
          cnt <= '0;
          if (prev && !line) state <= R_START;
        end
        R_START: begin
          // Mid-start-bit re-check rejects short glitches without an error.
          if (cnt == CW'(HALF - 1)) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= line ? R_IDLE : R_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        R_DATA: begin
          if (cnt == CW'(DIV - 1)) begin
            cnt     <= '0;
            shift   <= {line, shift[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) state <= R_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        R_STOP: begin
          if (cnt == CW'(DIV - 1)) begin
            cnt   <= '0;
            state <= R_IDLE;
            if (line) begin
              data  <= shift;
              valid <= 1'b1;
            end else begin
              stop_err <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_time_cmd_rx.sv
// Parses "T HH MM CR" command frames from the UART byte stream, range-checks
// the BCD time and presents it with a one-cycle time_set strobe.
module uart_time_cmd_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ     = 12_000_000,
  parameter int BAUD         = 9600,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       uart_rxd,
  output logic [3:0] time_hour_high,
  output logic [3:0] time_hour_low,
  output logic [3:0] time_min_high,
  output logic [3:0] time_min_low,
  output logic       time_set,
  output logic       frame_err,
  output logic [7:0] rx_byte,
  output logic       rx_valid
);

  localparam int DIV      = calc_div(CLK_FREQ, BAUD);
  localparam int TO_LIMIT = TIMEOUT_BITS * DIV;
  localparam int TW       = $clog2(TO_LIMIT + 1);

  logic          stop_err;
  parse_state_t  p_state;
  logic [3:0]    sh_hh, sh_hl, sh_mh, sh_ml;
  logic [TW-1:0] to_cnt;
  logic          is_digit;
  logic          range_ok;

  uart_byte_rx #(.DIV(DIV)) u_byte_rx (
    .clk      (sys_clk),
    .rst      (sys_rst),
    .rxd      (uart_rxd),
    .data     (rx_byte),
    .valid    (rx_valid),
    .stop_err (stop_err)
  );

  assign is_digit = (rx_byte >= CH_0) && (rx_byte <= CH_9);
  assign range_ok = ((sh_hh < 4'd2) || ((sh_hh == 4'd2) && (sh_hl <= 4'd3)))
                    && (sh_mh <= 4'd5);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      p_state        <= P_IDLE;
      sh_hh          <= '0;
      sh_hl          <= '0;
      sh_mh          <= '0;
      sh_ml          <= '0;
      to_cnt         <= '0;
      time_hour_high <= '0;
      time_hour_low  <= '0;
      time_min_high  <= '0;
      time_min_low   <= '0;
      time_set       <= 1'b0;
      frame_err      <= 1'b0;
    end else begin
      time_set  <= 1'b0;
      frame_err <= 1'b0;
      if (stop_err) begin
        p_state   <= P_IDLE;
        frame_err <= 1'b1;
        to_cnt    <= '0;
      end else if (rx_valid) begin
        // A byte arriving always beats a simultaneous timeout.
        to_cnt <= '0;
        if (rx_byte == CH_T) begin
          p_state <= P_H1;
        end else begin
          case (p_state)
            P_IDLE: p_state <= P_IDLE;
            P_H1, P_H0, P_M1, P_M0: begin
              if (is_digit) begin
                case (p_state)
                  P_H1:    begin sh_hh <= rx_byte[3:0]; p_state <= P_H0;  end
                  P_H0:    begin sh_hl <= rx_byte[3:0]; p_state <= P_M1;  end
                  P_M1:    begin sh_mh <= rx_byte[3:0]; p_state <= P_M0;  end
                  default: begin sh_ml <= rx_byte[3:0]; p_state <= P_END; end
                endcase
              end else begin
                frame_err <= 1'b1;
                p_state   <= P_IDLE;
              end
            end
            P_END: begin
              p_state <= P_IDLE;
              if ((rx_byte == CH_CR) && range_ok) begin
                time_hour_high <= sh_hh;
                time_hour_low  <= sh_hl;
                time_min_high  <= sh_mh;
                time_min_low   <= sh_ml;
                time_set       <= 1'b1;
              end else begin
                frame_err <= 1'b1;
              end
            end
            default: p_state <= P_IDLE;
          endcase
        end
      end else if (p_state != P_IDLE) begin
        if (to_cnt == TW'(TO_LIMIT - 1)) begin
          p_state   <= P_IDLE;
          frame_err <= 1'b1;
          to_cnt    <= '0;
        end else begin
          to_cnt <= to_cnt + 1'b1;
        end
      end else begin
        to_cnt <= '0;
      end
    end
  end

endmodule
